// File: rtl/poly_input_driver.sv
// Keypad front end: synchronises and debounces raw keys, assigns pressed notes to voices,
// and tracks octave and waveform mode from the control keys.
module poly_input_driver #(
    parameter int N_NOTES    = 13,
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 20,
    parameter int NUM_MODES  = 4,
    parameter int OCT_MAX    = 7,
    parameter int OCT_RESET  = 4,
    parameter int DEBOUNCE   = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_NOTES-1:0]              note_keys,
    input  logic [2:0]                      ctrl_keys,
    output logic [NUM_VOICES*DIV_W-1:0]     divider,
    output logic [NUM_VOICES-1:0]           voice_active,
    output logic [$clog2(NUM_MODES)-1:0]    mode,
    output logic [$clog2(OCT_MAX+1)-1:0]    octave,
    output logic                            busy
);
    localparam int NK     = N_NOTES + 3;
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int NOTE_W = $clog2(N_NOTES);
    localparam int VW     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int OCT_W  = $clog2(OCT_MAX + 1);
    localparam int MODE_W = $clog2(NUM_MODES);
    localparam int SH_W   = OCT_W + NOTE_W;

    // C0..B0 dividers for a 10 MHz clock; higher octaves are right shifts of these
    localparam logic [19:0] SEMI_ROM [12] = '{
        20'd611561, 20'd577237, 20'd544839, 20'd514259, 20'd485396, 20'd458153,
        20'd432439, 20'd408168, 20'd385259, 20'd363636, 20'd343227, 20'd323963
    };

    genvar gi;

    logic [NK-1:0]          raw;
    logic [NK-1:0]          deb;
    logic [NK-1:0]          deb_prev_reg;
    logic [NK-1:0]          rise;
    logic [N_NOTES-1:0]     fall;
    logic [2:0]             ctrl_rise;

    logic [N_NOTES-1:0]     pend_press_reg, pend_release_reg;
    logic [N_NOTES-1:0]     clr_press, clr_release;
    logic                   rel_found, press_found, held, free_found;
    logic [NOTE_W-1:0]      rel_idx, press_idx;
    logic [VW-1:0]          free_idx;

    logic [NUM_VOICES-1:0]  active_reg, active_next;
    logic [NOTE_W-1:0]      note_reg [NUM_VOICES];
    logic [NOTE_W-1:0]      note_next [NUM_VOICES];
    logic [VW-1:0]          steal_reg, steal_next;
    logic [DIV_W-1:0]       div_reg [NUM_VOICES];
    logic [DIV_W-1:0]       div_next [NUM_VOICES];
    logic [OCT_W-1:0]       octave_reg;
    logic [MODE_W-1:0]      mode_reg;

    assign raw = {ctrl_keys, note_keys};

    for (gi = 0; gi < NK; gi++) begin : g_key
        logic             sync1_reg, sync2_reg, deb_reg;
        logic [CNT_W-1:0] cnt_reg;

        // Any cycle where the synced value agrees with the accepted state restarts the count
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_reg <= 1'b0;
                sync2_reg <= 1'b0;
                deb_reg   <= 1'b0;
                cnt_reg   <= '0;
            end else begin
                sync1_reg <= raw[gi];
                sync2_reg <= sync1_reg;
                if (sync2_reg == deb_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_W'(DEBOUNCE - 1)) begin
                    deb_reg <= sync2_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end

        assign deb[gi] = deb_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_prev_reg <= '0;
        end else begin
            deb_prev_reg <= deb;
        end
    end

    assign rise      = deb & ~deb_prev_reg;
    assign fall      = ~deb[N_NOTES-1:0] & deb_prev_reg[N_NOTES-1:0];
    assign ctrl_rise = rise[NK-1:N_NOTES];

    // Lowest pending key of each class; descending scan so the lowest index wins
    always_comb begin
        rel_found   = 1'b0;
        rel_idx     = '0;
        press_found = 1'b0;
        press_idx   = '0;
        for (int n = N_NOTES - 1; n >= 0; n--) begin
            if (pend_release_reg[n]) begin
                rel_found = 1'b1;
                rel_idx   = NOTE_W'(n);
            end
            if (pend_press_reg[n]) begin
                press_found = 1'b1;
                press_idx   = NOTE_W'(n);
            end
        end
    end

    always_comb begin
        active_next = active_reg;
        note_next   = note_reg;
        steal_next  = steal_reg;
        clr_release = '0;
        clr_press   = '0;
        held        = 1'b0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (active_reg[v] && note_reg[v] == press_idx) begin
                held = 1'b1;
            end
            if (!active_reg[v]) begin
                free_found = 1'b1;
                free_idx   = VW'(v);
            end
        end
        if (rel_found) begin
            clr_release[rel_idx] = 1'b1;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_reg[v] && note_reg[v] == rel_idx) begin
                    active_next[v] = 1'b0;
                end
            end
        end else if (press_found) begin
            clr_press[press_idx] = 1'b1;
            if (!held) begin
                if (free_found) begin
                    active_next[free_idx] = 1'b1;
                    note_next[free_idx]   = press_idx;
                end else begin
                    note_next[steal_reg] = press_idx;
                    steal_next = (steal_reg == VW'(NUM_VOICES - 1)) ? '0 : steal_reg + VW'(1);
                end
            end
        end
    end

    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        logic [NOTE_W-1:0] semi, octs;
        logic [SH_W-1:0]   shift;

        assign semi  = note_next[gi] % NOTE_W'(12);
        assign octs  = note_next[gi] / NOTE_W'(12);
        assign shift = SH_W'(octave_reg) + SH_W'(octs);
        assign div_next[gi] = active_next[gi] ? (DIV_W'(SEMI_ROM[semi]) >> shift) : '0;
        assign divider[gi*DIV_W +: DIV_W] = div_reg[gi];
    end

    // Dividers are rebuilt every cycle, so an octave change reaches held notes one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_press_reg   <= '0;
            pend_release_reg <= '0;
            active_reg       <= '0;
            steal_reg        <= '0;
            octave_reg       <= OCT_W'(OCT_RESET);
            mode_reg         <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_reg[v] <= '0;
                div_reg[v]  <= '0;
            end
        end else begin
            pend_press_reg   <= (pend_press_reg & ~clr_press) | rise[N_NOTES-1:0];
            pend_release_reg <= (pend_release_reg & ~clr_release) | fall;
            active_reg       <= active_next;
            steal_reg        <= steal_next;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_reg[v] <= note_next[v];
                div_reg[v]  <= div_next[v];
            end
            if (ctrl_rise[0] && !ctrl_rise[1] && octave_reg != OCT_W'(OCT_MAX)) begin
                octave_reg <= octave_reg + OCT_W'(1);
            end else if (ctrl_rise[1] && !ctrl_rise[0] && octave_reg != '0) begin
                octave_reg <= octave_reg - OCT_W'(1);
            end
            if (ctrl_rise[2]) begin
                mode_reg <= (mode_reg == MODE_W'(NUM_MODES - 1)) ? '0 : mode_reg + MODE_W'(1);
            end
        end
    end

    assign voice_active = active_reg;
    assign octave       = octave_reg;
    assign mode         = mode_reg;
    assign busy         = |(pend_press_reg | pend_release_reg);

endmodule
